// File: rtl/output_drain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : output_drain_pkg                                                 |
// | Purpose : Shared types and widths for the output drain stage: the tagged   |
// |           result record, the drain FSM state encoding and the coordinate   |
// |           tag widths.                                                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package output_drain_pkg;

   localparam int DATA_W = 32;            // accumulated result width
   localparam int XW     = $clog2(64);    // feature-map x tag width
   localparam int YW     = $clog2(64);    // feature-map y tag width
   localparam int CW     = $clog2(32);    // output channel tag width

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [XW-1:0]     x;
      logic [YW-1:0]     y;
      logic [CW-1:0]     ch;
   } result_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      TURN_ON  = 3'd2,
      SEND     = 3'd3,
      TURN_OFF = 3'd4
   } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/output_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : output_fifo                                                      |
// | Purpose : Result buffer of result_t records. Pointers carry one extra MSB  |
// |           so full and empty are distinguished without a separate counter.  |
// | Ports   : clk, rst          clock, synchronous active-high reset           |
// |           push_i, data_i    write request and record (ignored when full)   |
// |           pop_i             read request (ignored when empty)              |
// |           head_o            oldest record                                  |
// |           head_next_o       record behind the oldest (valid if count>=2)   |
// |           count_o           number of stored records                       |
// |           full_o, empty_o   occupancy flags                                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module output_fifo
   import output_drain_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  result_t                    data_i,
   input  logic                       pop_i,
   output result_t                    head_o,
   output result_t                    head_next_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
         $error("output_fifo: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   result_t         mem_q [DEPTH];
   logic [AW:0]     wr_q;
   logic [AW:0]     rd_q;
   logic [AW-1:0]   w_rd_nxt;
   logic            w_push;
   logic            w_pop;

   assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o  = (wr_q == rd_q);
   assign count_o  = wr_q - rd_q;
   assign w_push   = push_i && !full_o;
   assign w_pop    = pop_i && !empty_o;
   assign w_rd_nxt = rd_q[AW-1:0] + AW'(1);

   assign head_o      = mem_q[rd_q[AW-1:0]];
   assign head_next_o = mem_q[w_rd_nxt];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (w_push) wr_q <= wr_q + (AW+1)'(1);
         if (w_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/output_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : output_drain                                                     |
// | Purpose : Buffers finished output activations with their (x,y,ch) tags and |
// |           drains them onto the shared con_1/con_2/con_3 bus, handling bus  |
// |           request/grant, one-cycle turnaround on and off, and a bounded    |
// |           burst length per bus tenure.                                     |
// | Ports   : result_*           producer side (valid/ready + record)          |
// |           bus_req/bus_grant  bus ownership handshake with input loader     |
// |           con_1/2/3          data low half, data high half, channel tag    |
// |           con_valid/ready    beat handshake; output_* mirror current beat  |
// |           driving_cons       tri-state enable for the con_* lanes          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module output_drain
   import output_drain_pkg::*;
#(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int ACCUMULATION_WIDTH = 32,
   parameter int FEATURE_MAP_WIDTH  = 64,
   parameter int FEATURE_MAP_HEIGHT = 64,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int FIFO_DEPTH         = 8,
   parameter int MAX_BURST          = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          result_valid,
   output logic                          result_ready,
   input  logic [ACCUMULATION_WIDTH-1:0] result_data,
   input  logic [XW-1:0]                 result_x,
   input  logic [YW-1:0]                 result_y,
   input  logic [CW-1:0]                 result_ch,
   output logic                          bus_req,
   input  logic                          bus_grant,
   output logic [IO_DATA_WIDTH-1:0]      con_1,
   output logic [IO_DATA_WIDTH-1:0]      con_2,
   output logic [IO_DATA_WIDTH-1:0]      con_3,
   output logic                          con_valid,
   input  logic                          con_ready,
   output logic                          driving_cons,
   output logic                          output_valid,
   output logic [XW-1:0]                 output_x,
   output logic [YW-1:0]                 output_y,
   output logic [CW-1:0]                 output_ch
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BW    = $clog2(MAX_BURST);

   generate
      if ((ACCUMULATION_WIDTH != 2 * IO_DATA_WIDTH) || (ACCUMULATION_WIDTH != DATA_W) ||
          ($clog2(FEATURE_MAP_WIDTH) != XW) || ($clog2(FEATURE_MAP_HEIGHT) != YW) ||
          ($clog2(OUTPUT_NB_CHANNELS) != CW) || (CW > IO_DATA_WIDTH)) begin : g_cfg_check
         $error("output_drain: width parameters inconsistent with output_drain_pkg");
      end
   endgenerate

   drain_state_e      state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic              vld_q, vld_d;
   result_t           out_q, out_d;

   result_t           w_in;
   result_t           w_head;
   result_t           w_head_next;
   logic [CNT_W-1:0]  w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   assign w_in   = '{data: result_data, x: result_x, y: result_y, ch: result_ch};
   assign w_push = result_valid && !w_full;
   assign w_pop  = vld_q && con_ready;

   output_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (w_push),
      .data_i      (w_in),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .head_next_o (w_head_next),
      .count_o     (w_count),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   // The beat register always mirrors the FIFO head while valid; the entry is
   // only popped when the beat is accepted, so a grant loss never loses data.
   // The first SEND cycle loads the register, so beats start one cycle later.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      vld_d   = 1'b0;
      out_d   = '0;
      case (state_q)
         IDLE: begin
            beat_d = '0;
            if (!w_empty) state_d = REQ;
         end
         REQ: begin
            if (bus_grant) state_d = TURN_ON;
         end
         TURN_ON: begin
            state_d = bus_grant ? SEND : TURN_OFF;
         end
         SEND: begin
            if (w_pop) beat_d = beat_q + BW'(1);
            if (!bus_grant) begin
               state_d = TURN_OFF;
            end else if (w_pop && ((beat_q == BW'(MAX_BURST - 1)) ||
                                   ((w_count == CNT_W'(1)) && !w_push))) begin
               state_d = TURN_OFF;
            end else if (w_empty) begin
               state_d = TURN_OFF;
            end else if (vld_q && !con_ready) begin
               vld_d = 1'b1;
               out_d = out_q;
            end else if (w_pop) begin
               // Next head is only taken if it is already stored; a record
               // arriving in this very cycle is picked up one cycle later.
               if (w_count >= CNT_W'(2)) begin
                  vld_d = 1'b1;
                  out_d = w_head_next;
               end
            end else begin
               vld_d = 1'b1;
               out_d = w_head;
            end
         end
         TURN_OFF: begin
            beat_d  = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         vld_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         vld_q   <= vld_d;
         out_q   <= out_d;
      end
   end

   assign result_ready = !w_full;
   assign bus_req      = (state_q == REQ) || (state_q == TURN_ON) || (state_q == SEND);
   assign driving_cons = (state_q == TURN_ON) || (state_q == SEND);
   assign con_valid    = vld_q;
   assign output_valid = vld_q;
   assign con_1        = out_q.data[IO_DATA_WIDTH-1:0];
   assign con_2        = out_q.data[2*IO_DATA_WIDTH-1:IO_DATA_WIDTH];
   assign con_3        = {{(IO_DATA_WIDTH - CW){1'b0}}, out_q.ch};
   assign output_x     = out_q.x;
   assign output_y     = out_q.y;
   assign output_ch    = out_q.ch;

   // Losing the grant while driving the bus is a loader-side protocol error.
   ap_grant_held: assert property (@(posedge clk) disable iff (rst)
      ((state_q == TURN_ON) || (state_q == SEND)) |-> bus_grant);

endmodule
`default_nettype wire
